// File: rtl/instruction_fetch.sv
// Fetch/decode front end: owns the PC, addresses the combinational program ROM and splits words into fields.
// Define FETCH_NOP_DELAY_EN to turn the NOP operand into a multi-cycle delay (adds DELAY state and counter).
`ifndef NOP
`define NOP 4'd0
`endif
`ifndef JMP
`define JMP 4'd5
`endif

module instruction_fetch (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic        oValid,
    output logic [3:0]  oOperation,
    output logic [7:0]  oDestination,
    output logic [7:0]  oSourceAddr1,
    output logic [7:0]  oSourceAddr0,
    output logic [15:0] oImmediate
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 8;

    localparam logic [OP_W-1:0] OP_NOP = `NOP;
    localparam logic [OP_W-1:0] OP_JMP = `JMP;

    logic [PC_W-1:0]  pc_q,    pc_d;
    logic             valid_q, valid_d;
    logic [OP_W-1:0]  op_q,    op_d;
    logic [REG_W-1:0] dst_q,   dst_d;
    logic [PC_W-1:0]  imm_q,   imm_d;

    logic [OP_W-1:0]  ins_op;
    logic [REG_W-1:0] ins_dst;
    logic [PC_W-1:0]  ins_imm;

    assign ins_op  = iInstruction[27:24];
    assign ins_dst = iInstruction[23:16];
    assign ins_imm = iInstruction[15:0];

`ifdef FETCH_NOP_DELAY_EN
    localparam int unsigned CNT_W = 24;

    typedef enum logic {
        S_FETCH,
        S_DELAY
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] nop_len;

    assign nop_len = iInstruction[23:0];
`endif

    // Next-state: branch redirect wins, then the NOP delay countdown, then stall, then decode.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        op_d    = op_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
`ifdef FETCH_NOP_DELAY_EN
        state_d = state_q;
        cnt_d   = cnt_q;
`endif
        if (iBranchTaken) begin
            pc_d    = iBranchTarget;
            valid_d = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            state_d = S_FETCH;
            cnt_d   = '0;
`endif
        end
`ifdef FETCH_NOP_DELAY_EN
        else if (state_q == S_DELAY) begin
            // The countdown keeps running even while execute is stalled.
            valid_d = 1'b0;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_FETCH;
            end
        end
`endif
        else if (!iStall) begin
            case (ins_op)
                OP_JMP: begin
                    pc_d    = ins_imm;
                    valid_d = 1'b0;
                end
                OP_NOP: begin
                    pc_d    = pc_q + PC_W'(1);
                    valid_d = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
                    if (nop_len >= CNT_W'(2)) begin
                        cnt_d   = nop_len - CNT_W'(1);
                        state_d = S_DELAY;
                    end
`endif
                end
                default: begin
                    pc_d    = pc_q + PC_W'(1);
                    valid_d = 1'b1;
                    op_d    = ins_op;
                    dst_d   = ins_dst;
                    imm_d   = ins_imm;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
            op_q    <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
`ifdef FETCH_NOP_DELAY_EN
            state_q <= S_FETCH;
            cnt_q   <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
`ifdef FETCH_NOP_DELAY_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign oAddress     = pc_q;
    assign oValid       = valid_q;
    assign oOperation   = op_q;
    assign oDestination = dst_q;
    assign oSourceAddr1 = imm_q[15:8];
    assign oSourceAddr0 = imm_q[7:0];
    assign oImmediate   = imm_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: ROM model, table of per-edge vectors, hand sequences for NOP/reset.
`ifndef NOP
`define NOP 4'd0
`endif
`ifndef JMP
`define JMP 4'd5
`endif

module tb_instruction_fetch;

    localparam logic [3:0] OP_NOP = `NOP;
    localparam logic [3:0] OP_JMP = `JMP;
    localparam logic [3:0] OP_STO = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    logic        Clock;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oValid;
    logic [3:0]  oOperation;
    logic [7:0]  oDestination;
    logic [7:0]  oSourceAddr1;
    logic [7:0]  oSourceAddr0;
    logic [15:0] oImmediate;

    logic [27:0] rom [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic        valid;
        logic [3:0]  op;
        logic [7:0]  dst;
        logic [15:0] imm;
    } vec_t;

    vec_t vq [$];

    instruction_fetch dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oValid        (oValid),
        .oOperation    (oOperation),
        .oDestination  (oDestination),
        .oSourceAddr1  (oSourceAddr1),
        .oSourceAddr0  (oSourceAddr0),
        .oImmediate    (oImmediate)
    );

    assign iInstruction = rom[oAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] a, input logic v,
                           input logic [3:0] op, input logic [7:0] d, input logic [15:0] imm);
        chk({tag, " addr"}, 32'(oAddress), 32'(a));
        chk({tag, " valid"}, 32'(oValid), 32'(v));
        if (v) begin
            chk({tag, " op"}, 32'(oOperation), 32'(op));
            chk({tag, " dst"}, 32'(oDestination), 32'(d));
            chk({tag, " src1"}, 32'(oSourceAddr1), 32'(imm[15:8]));
            chk({tag, " src0"}, 32'(oSourceAddr0), 32'(imm[7:0]));
            chk({tag, " imm"}, 32'(oImmediate), 32'(imm));
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [15:0] t);
        iStall        = s;
        iBranchTaken  = b;
        iBranchTarget = t;
        @(posedge Clock);
        #1;
    endtask

    task automatic add(input logic s, input logic b, input logic [15:0] t, input logic [15:0] a,
                       input logic v, input logic [3:0] op, input logic [7:0] d, input logic [15:0] imm);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.addr = a;
        x.valid = v; x.op = op; x.dst = d; x.imm = imm;
        vq.push_back(x);
    endtask

    initial begin
        int bub;
        int exp_bub;

        Reset         = 1'b0;
        iStall        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 16'h0000;

        for (int i = 0; i < 65536; i++) rom[i] = {OP_ADD, 8'(i), 16'(i)};
        rom[16'h0000] = {OP_ADD, 8'h01, 16'h0203};
        rom[16'h0001] = {OP_STO, 8'h00, 16'd65305};
        rom[16'h0002] = {OP_SUB, 8'h04, 16'h0506};
        rom[16'h0003] = {OP_MUL, 8'h00, 16'h0001};
        rom[16'h0004] = {OP_ADD, 8'h07, 16'h0809};
        rom[16'h0005] = {OP_SUB, 8'h0A, 16'h0B0C};
        rom[16'h0006] = {OP_ADD, 8'h0D, 16'h0E0F};
        rom[16'h0007] = {OP_JMP, 8'h00, 16'h0000};
        rom[16'h0010] = {OP_STO, 8'h11, 16'h1234};
        rom[16'h0020] = {OP_NOP, 24'd4000};
        rom[16'h0030] = {OP_NOP, 24'd1};
        rom[16'h0040] = {OP_NOP, 24'd10};
        rom[16'hFFFF] = {OP_ADD, 8'hAA, 16'hBBCC};

        // stall, br, target | addr, valid, op, dst, imm
        add(0, 0, 16'h0000, 16'h0001, 1, OP_ADD, 8'h01, 16'h0203);
        add(0, 0, 16'h0000, 16'h0002, 1, OP_STO, 8'h00, 16'hFF19);
        add(0, 0, 16'h0000, 16'h0003, 1, OP_SUB, 8'h04, 16'h0506);
        add(0, 0, 16'h0000, 16'h0004, 1, OP_MUL, 8'h00, 16'h0001);
        add(1, 0, 16'h0000, 16'h0004, 1, OP_MUL, 8'h00, 16'h0001);
        add(1, 0, 16'h0000, 16'h0004, 1, OP_MUL, 8'h00, 16'h0001);
        add(1, 0, 16'h0000, 16'h0004, 1, OP_MUL, 8'h00, 16'h0001);
        add(1, 1, 16'h0010, 16'h0010, 0, 4'h0,   8'h00, 16'h0000);
        add(0, 0, 16'h0000, 16'h0011, 1, OP_STO, 8'h11, 16'h1234);
        add(0, 0, 16'h0000, 16'h0012, 1, OP_ADD, 8'h11, 16'h0011);
        add(0, 1, 16'h0004, 16'h0004, 0, 4'h0,   8'h00, 16'h0000);
        add(0, 0, 16'h0000, 16'h0005, 1, OP_ADD, 8'h07, 16'h0809);
        add(0, 0, 16'h0000, 16'h0006, 1, OP_SUB, 8'h0A, 16'h0B0C);
        add(0, 0, 16'h0000, 16'h0007, 1, OP_ADD, 8'h0D, 16'h0E0F);
        add(0, 0, 16'h0000, 16'h0000, 0, 4'h0,   8'h00, 16'h0000);
        add(0, 0, 16'h0000, 16'h0001, 1, OP_ADD, 8'h01, 16'h0203);
        add(0, 0, 16'h0000, 16'h0002, 1, OP_STO, 8'h00, 16'hFF19);
        add(0, 1, 16'hFFFF, 16'hFFFF, 0, 4'h0,   8'h00, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, OP_ADD, 8'hAA, 16'hBBCC);
        add(0, 0, 16'h0000, 16'h0001, 1, OP_ADD, 8'h01, 16'h0203);
        add(0, 1, 16'h0030, 16'h0030, 0, 4'h0,   8'h00, 16'h0000);
        add(0, 0, 16'h0000, 16'h0031, 0, 4'h0,   8'h00, 16'h0000);
        add(0, 0, 16'h0000, 16'h0032, 1, OP_ADD, 8'h31, 16'h0031);

        #12;
        chk("reset addr", 32'(oAddress), 32'h0);
        chk("reset valid", 32'(oValid), 32'h0);
        chk("reset op", 32'(oOperation), 32'h0);
        chk("reset dst", 32'(oDestination), 32'h0);
        chk("reset imm", 32'(oImmediate), 32'h0);
        Reset = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].stall, vq[i].br, vq[i].tgt);
            chk_out($sformatf("vec%0d", i), vq[i].addr, vq[i].valid, vq[i].op, vq[i].dst, vq[i].imm);
        end

        // NOP 4000: count bubble edges after the NOP is fetched.
`ifdef FETCH_NOP_DELAY_EN
        exp_bub = 4000;
`else
        exp_bub = 1;
`endif
        step(0, 1, 16'h0020);
        chk_out("nop br", 16'h0020, 1'b0, 4'h0, 8'h00, 16'h0000);
        bub = 0;
        for (int k = 0; k < 5000; k++) begin
            step(0, 0, 16'h0000);
            if (oValid) break;
            bub++;
            if (bub == 100) chk("nop pc hold", 32'(oAddress), 32'h21);
        end
        chk("nop bubbles", 32'(bub), 32'(exp_bub));
        chk_out("nop after", 16'h0022, 1'b1, OP_ADD, 8'h21, 16'h0021);

`ifdef FETCH_NOP_DELAY_EN
        // Branch aborts an in-progress delay.
        step(0, 1, 16'h0020);
        step(0, 0, 16'h0000);
        chk_out("dly nop", 16'h0021, 1'b0, 4'h0, 8'h00, 16'h0000);
        repeat (5) step(0, 0, 16'h0000);
        step(0, 1, 16'h0010);
        chk_out("dly br", 16'h0010, 1'b0, 4'h0, 8'h00, 16'h0000);
        step(0, 0, 16'h0000);
        chk_out("dly tgt", 16'h0011, 1'b1, OP_STO, 8'h11, 16'h1234);

        // Countdown continues under stall: NOP 10 gives 10 bubbles total.
        step(0, 1, 16'h0040);
        step(0, 0, 16'h0000);
        chk_out("stl nop", 16'h0041, 1'b0, 4'h0, 8'h00, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            step(1, 0, 16'h0000);
            chk_out($sformatf("stl dly%0d", k), 16'h0041, 1'b0, 4'h0, 8'h00, 16'h0000);
        end
        step(0, 0, 16'h0000);
        chk_out("stl after", 16'h0042, 1'b1, OP_ADD, 8'h41, 16'h0041);
`endif

        // Asynchronous reset mid-run with PC=5.
        step(0, 1, 16'h0005);
        chk_out("pre rst", 16'h0005, 1'b0, 4'h0, 8'h00, 16'h0000);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid rst addr", 32'(oAddress), 32'h0);
        chk("mid rst valid", 32'(oValid), 32'h0);
        chk("mid rst op", 32'(oOperation), 32'h0);
        chk("mid rst dst", 32'(oDestination), 32'h0);
        chk("mid rst src1", 32'(oSourceAddr1), 32'h0);
        chk("mid rst src0", 32'(oSourceAddr0), 32'h0);
        chk("mid rst imm", 32'(oImmediate), 32'h0);
        Reset = 1'b1;
        step(0, 0, 16'h0000);
        chk_out("rel e1", 16'h0001, 1'b1, OP_ADD, 8'h01, 16'h0203);
        step(0, 0, 16'h0000);
        chk_out("rel e2", 16'h0002, 1'b1, OP_STO, 8'h00, 16'd65305);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
